ov7620_capture_module: RTL and testbench
========================================

Name: ov7620_capture_module

Overview:
Front-end for the OV7620 camera path. Sits directly upstream of the SRAM controller and brings the camera's asynchronous PCLK, VSYNC, HREF and Y[7:0] into the system CLK domain. Produces single-cycle edge strobes and a registered Y byte aligned to each pixel strobe. Tracks line/pixel position per frame and flags frames that are not exactly H_PIXELS x V_LINES.

Parameters:
H_PIXELS, 640, expected pixel strobes per HREF-high window
V_LINES, 240, expected HREF windows per frame
SYNC_STAGES, 2, flip-flop stages on each camera control input (min 2)
VS_ACTIVE_HIGH, 1, 1 = VSYNC pulse high marks frame boundary; 0 = inverted

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
Capture_En  in  1  level; 1 = arm capture at next frame start
CAM_PCLK  in  1  camera pixel clock, async, sampled as data
CAM_VSYNC  in  1  camera frame sync, async
CAM_HREF  in  1  camera line valid, async
CAM_Y  in  8  camera luma bus, async
H2L_Sig_V  out  1  1-cycle pulse, synced VSYNC active->inactive (frame start)
L2H_Sig_V  out  1  1-cycle pulse, synced VSYNC inactive->active (frame end)
L2H_Sig_H  out  1  1-cycle pulse, synced HREF rising
Href_Level  out  1  synced HREF level
L2H_Sig_P  out  1  1-cycle pixel strobe: synced PCLK rising while Href_Level=1 and state ACTIVE
Y_Data  out  8  luma byte, valid in the cycle L2H_Sig_P=1, held until next strobe
Pixel_Col  out  10  column index of current Y_Data (0..H_PIXELS-1)
Line_Row  out  9  line index of current Y_Data (0..V_LINES-1)
Frame_Done  out  1  1-cycle pulse at frame end when frame was in ACTIVE
Frame_Err  out  1  sticky; set on geometry mismatch, cleared at next frame start
Frame_Cnt  out  8  completed good frames, wraps 255->0

Behaviour:
- Reset: all outputs 0; all sync registers 0; state IDLE.
- CAM_PCLK/VSYNC/HREF pass through SYNC_STAGES flops plus one history flop. Edge = (sync & ~hist) or its inverse. Latency is input change -> pulse = SYNC_STAGES+1 CLK (3 at default). VSYNC is inverted internally when VS_ACTIVE_HIGH=0.
- CAM_Y passes through a SYNC_STAGES-deep plain register pipe, so each byte stays aligned with its PCLK. On L2H_Sig_P, Y_Data loads the pipe output in the same cycle the strobe is asserted (registered output; strobe and data are coincident).
- CLK must be >= 3x PCLK. Bench runs 50 MHz vs 12.5 MHz.
- FSM:
  - IDLE: wait for Capture_En=1 -> WAIT_VS.
  - WAIT_VS: on H2L_Sig_V -> ACTIVE. Clear Line_Row, Pixel_Col, line-pixel counter, Frame_Err.
  - ACTIVE:
    - Pixel strobe: Y_Data and Pixel_Col = line-pixel counter are output, then the counter increments. The counter saturates at H_PIXELS; strobes beyond that set Frame_Err and are suppressed (no L2H_Sig_P).
    - HREF falling: if counter != H_PIXELS, set Frame_Err. Clear the counter. Line counter increments (saturates at V_LINES; extra line sets Frame_Err and its strobes are suppressed).
    - L2H_Sig_V: if line count != V_LINES, set Frame_Err. Pulse Frame_Done the next cycle. If Frame_Err=0, Frame_Cnt increments. Then -> WAIT_VS if Capture_En=1, else IDLE.
- Capture_En dropping mid-frame has no effect until frame end (whole frames only).
- H2L_Sig_V seen while in ACTIVE (VSYNC glitch, no prior L2H_Sig_V): set Frame_Err, no Frame_Done, restart as a new frame (counters cleared, Frame_Err then re-cleared per the WAIT_VS rule; the Frame_Err pulse is visible for 1 cycle).
- L2H_Sig_V, H2L_Sig_V and L2H_Sig_H are emitted in every state. L2H_Sig_P only in ACTIVE.
- Simultaneous HREF falling and pixel strobe in the same CLK: process the pixel first, then the line-end check.
- RST asserted mid-frame: everything to reset values next edge. After release, capture resumes only at the next H2L_Sig_V.

Decomposition:
- Shared package cam_pkg: H_PIXELS/V_LINES defaults, FSM state encoding (IDLE=0, WAIT_VS=1, ACTIVE=2), counter widths.
- One sub-module: cam_sync_edge (parameterised SYNC_STAGES; outputs synced level, rise pulse, fall pulse), instanced for PCLK, VSYNC, HREF.

Test Plan:
- Reset then nominal frame: Capture_En=1, 240 lines x 640 pixels, Y=col[7:0]. Expect 153600 L2H_Sig_P, Y_Data matching the pixel ramp, last Pixel_Col=639/Line_Row=239, one Frame_Done, Frame_Cnt=1, Frame_Err=0.
- Short line: line 10 has 639 pixels. Expect Frame_Err=1 after that HREF fall, Frame_Done pulses, Frame_Cnt stays 0. Next good frame clears Frame_Err and gives Frame_Cnt=1.
- Long frame: 241 lines. Line 241 produces no L2H_Sig_P, Frame_Err=1.
- Latency check: single VSYNC edge. H2L_Sig_V is exactly 3 CLK after the input change, width 1 CLK.
- Capture_En deasserted at line 100: frame completes (Frame_Done, Frame_Cnt++), then IDLE. Next frame produces no L2H_Sig_P.
- RST held 2 cycles at line 50: all outputs 0. Remainder of that frame produces no L2H_Sig_P. Next frame captured fully.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared constants for the OV7620 capture path: default frame geometry,
// counter widths and FSM state encoding.
package cam_pkg;

  localparam int H_PIXELS_DEF = 640;
  localparam int V_LINES_DEF  = 240;

  localparam int COL_W      = 10;
  localparam int ROW_W      = 9;
  localparam int PIX_CNT_W  = 11;
  localparam int LINE_CNT_W = 10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_VS = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;

endpackage

// File: rtl/cam_sync_edge.sv
// Multi-stage synchroniser for one asynchronous camera control line, with a
// history flop so rising/falling edges come out as one-cycle pulses.
module cam_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/ov7620_capture_module.sv
// OV7620 camera front-end: brings PCLK/VSYNC/HREF/Y into the CLK domain,
// emits pixel strobes with aligned luma, and checks frame geometry.
module ov7620_capture_module
  import cam_pkg::*;
#(
  parameter int H_PIXELS       = H_PIXELS_DEF,
  parameter int V_LINES        = V_LINES_DEF,
  parameter int SYNC_STAGES    = 2,
  parameter int VS_ACTIVE_HIGH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Capture_En,
  input  logic             CAM_PCLK,
  input  logic             CAM_VSYNC,
  input  logic             CAM_HREF,
  input  logic [7:0]       CAM_Y,
  output logic             H2L_Sig_V,
  output logic             L2H_Sig_V,
  output logic             L2H_Sig_H,
  output logic             Href_Level,
  output logic             L2H_Sig_P,
  output logic [7:0]       Y_Data,
  output logic [COL_W-1:0] Pixel_Col,
  output logic [ROW_W-1:0] Line_Row,
  output logic             Frame_Done,
  output logic             Frame_Err,
  output logic [7:0]       Frame_Cnt
);

  localparam logic [PIX_CNT_W-1:0]  H_MAX = PIX_CNT_W'(H_PIXELS);
  localparam logic [LINE_CNT_W-1:0] V_MAX = LINE_CNT_W'(V_LINES);

  logic vs_in;
  logic p_level, p_rise, p_fall;
  logic v_level, v_rise, v_fall;
  logic h_level, h_rise, h_fall;
  logic unused_sync;

  assign vs_in = (VS_ACTIVE_HIGH != 0) ? CAM_VSYNC : ~CAM_VSYNC;

  cam_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pclk (
    .clk(CLK), .rst(RST), .din(CAM_PCLK), .level(p_level), .rise(p_rise), .fall(p_fall)
  );
  cam_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_vsync (
    .clk(CLK), .rst(RST), .din(vs_in), .level(v_level), .rise(v_rise), .fall(v_fall)
  );
  cam_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_href (
    .clk(CLK), .rst(RST), .din(CAM_HREF), .level(h_level), .rise(h_rise), .fall(h_fall)
  );

  assign unused_sync = ^{p_level, p_fall, v_level};
  assign Href_Level  = h_level;

  // Luma delayed by the same depth as the control synchronisers keeps each byte with its PCLK edge.
  logic [7:0] y_pipe [SYNC_STAGES];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) y_pipe[i] <= '0;
    end else begin
      y_pipe[0] <= CAM_Y;
      for (int i = 1; i < SYNC_STAGES; i++) y_pipe[i] <= y_pipe[i-1];
    end
  end

  logic [1:0]            state, state_n;
  logic [PIX_CNT_W-1:0]  pix_cnt, pix_n;
  logic [LINE_CNT_W-1:0] line_cnt, line_n;
  logic                  err_n, strobe_n;
  logic                  done_pend, done_pend_n;
  logic                  good_pend, good_pend_n;
  logic                  restart, restart_n;

  // Within one cycle the pixel is handled first, then the line end, then the frame end.
  always_comb begin
    state_n     = state;
    pix_n       = pix_cnt;
    line_n      = line_cnt;
    err_n       = Frame_Err;
    strobe_n    = 1'b0;
    done_pend_n = 1'b0;
    good_pend_n = 1'b0;
    restart_n   = 1'b0;
    if (restart) err_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Capture_En) state_n = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (v_fall) begin
          state_n = ST_ACTIVE;
          pix_n   = '0;
          line_n  = '0;
          err_n   = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (v_fall) begin
          err_n     = 1'b1;
          pix_n     = '0;
          line_n    = '0;
          restart_n = 1'b1;
        end else begin
          if (p_rise && h_level) begin
            if (pix_cnt < H_MAX && line_cnt < V_MAX) begin
              strobe_n = 1'b1;
              pix_n    = pix_cnt + 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
          if (h_fall) begin
            if (pix_n != H_MAX) err_n = 1'b1;
            pix_n = '0;
            if (line_cnt < V_MAX) line_n = line_cnt + 1'b1;
            else err_n = 1'b1;
          end
          if (v_rise) begin
            if (line_n != V_MAX) err_n = 1'b1;
            done_pend_n = 1'b1;
            good_pend_n = ~err_n;
            state_n     = Capture_En ? ST_WAIT_VS : ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      done_pend  <= 1'b0;
      good_pend  <= 1'b0;
      restart    <= 1'b0;
      H2L_Sig_V  <= 1'b0;
      L2H_Sig_V  <= 1'b0;
      L2H_Sig_H  <= 1'b0;
      L2H_Sig_P  <= 1'b0;
      Y_Data     <= '0;
      Pixel_Col  <= '0;
      Line_Row   <= '0;
      Frame_Done <= 1'b0;
      Frame_Err  <= 1'b0;
      Frame_Cnt  <= '0;
    end else begin
      state      <= state_n;
      pix_cnt    <= pix_n;
      line_cnt   <= line_n;
      done_pend  <= done_pend_n;
      good_pend  <= good_pend_n;
      restart    <= restart_n;
      H2L_Sig_V  <= v_fall;
      L2H_Sig_V  <= v_rise;
      L2H_Sig_H  <= h_rise;
      L2H_Sig_P  <= strobe_n;
      Frame_Err  <= err_n;
      Frame_Done <= done_pend;
      if (strobe_n) begin
        Y_Data    <= y_pipe[SYNC_STAGES-1];
        Pixel_Col <= pix_cnt[COL_W-1:0];
        Line_Row  <= line_cnt[ROW_W-1:0];
      end
      if (done_pend && good_pend) Frame_Cnt <= Frame_Cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ov7620_capture_module.sv
// Directed bench for ov7620_capture_module on a reduced 8x4 frame geometry,
// CLK 50 MHz against a free-running 12.5 MHz PCLK.
module tb_ov7620_capture_module;

  localparam int H = 8;
  localparam int V = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       capture_en;
  logic       cam_pclk = 1'b0;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_y;

  logic       h2l_sig_v, l2h_sig_v, l2h_sig_h, href_level, l2h_sig_p;
  logic [7:0] y_data;
  logic [9:0] pixel_col;
  logic [8:0] line_row;
  logic       frame_done, frame_err;
  logic [7:0] frame_cnt;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int check_cnt = 0;
  int done_cnt  = 0;
  logic [26:0] strobe_q [$];

  ov7620_capture_module #(
    .H_PIXELS(H), .V_LINES(V), .SYNC_STAGES(2), .VS_ACTIVE_HIGH(1)
  ) dut (
    .CLK(clk), .RST(rst), .Capture_En(capture_en),
    .CAM_PCLK(cam_pclk), .CAM_VSYNC(cam_vsync), .CAM_HREF(cam_href), .CAM_Y(cam_y),
    .H2L_Sig_V(h2l_sig_v), .L2H_Sig_V(l2h_sig_v), .L2H_Sig_H(l2h_sig_h),
    .Href_Level(href_level), .L2H_Sig_P(l2h_sig_p), .Y_Data(y_data),
    .Pixel_Col(pixel_col), .Line_Row(line_row), .Frame_Done(frame_done),
    .Frame_Err(frame_err), .Frame_Cnt(frame_cnt)
  );

  always #10 clk = ~clk;

  initial begin
    #5;
    forever #40 cam_pclk = ~cam_pclk;
  end

  always @(negedge clk) begin
    if (l2h_sig_p) strobe_q.push_back({line_row, pixel_col, y_data});
    if (frame_done) done_cnt++;
  end

  function automatic logic [7:0] pix_val(input int row, input int col);
    return 8'(row * 16 + col + 1);
  endfunction

  function automatic logic [63:0] all_outputs();
    return 64'({h2l_sig_v, l2h_sig_v, l2h_sig_h, href_level, l2h_sig_p, y_data,
                pixel_col, line_row, frame_done, frame_err, frame_cnt});
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_monitor();
    strobe_q.delete();
    done_cnt = 0;
  endtask

  task automatic send_line(input int row, input int npix);
    @(negedge cam_pclk);
    cam_href = 1'b1;
    for (int c = 0; c < npix; c++) begin
      cam_y = pix_val(row, c);
      @(negedge cam_pclk);
    end
    cam_href = 1'b0;
    cam_y    = 8'h00;
    repeat (2) @(negedge cam_pclk);
  endtask

  task automatic send_lines(input int nlines, input int short_row);
    for (int r = 0; r < nlines; r++) send_line(r, (r == short_row) ? H - 1 : H);
  endtask

  task automatic frame_start();
    @(negedge cam_pclk);
    cam_vsync = 1'b0;
    repeat (3) @(negedge cam_pclk);
  endtask

  task automatic frame_end();
    @(negedge cam_pclk);
    cam_vsync = 1'b1;
    repeat (4) @(negedge cam_pclk);
  endtask

  task automatic apply_stimulus(input int nlines, input int short_row);
    clear_monitor();
    frame_start();
    send_lines(nlines, short_row);
    frame_end();
  endtask

  initial begin
    rst        = 1'b1;
    capture_en = 1'b0;
    cam_vsync  = 1'b1;
    cam_href   = 1'b0;
    cam_y      = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_output("reset_outputs", all_outputs(), 64'd0);
    rst = 1'b0;
    capture_en = 1'b1;
    repeat (4) @(posedge clk);

    // Nominal frame: every pixel with its row, column and luma
    apply_stimulus(V, -1);
    check_output("nominal_strobes", 64'(strobe_q.size()), 64'd32);
    for (int i = 0; i < H * V; i++)
      check_output("nominal_pixel", 64'(strobe_q[i]),
                   64'({9'(i / H), 10'(i % H), pix_val(i / H, i % H)}));
    check_output("nominal_done", 64'(done_cnt), 64'd1);
    check_output("nominal_cnt", 64'(frame_cnt), 64'd1);
    check_output("nominal_err", 64'(frame_err), 64'd0);

    // Row 1 one pixel short
    apply_stimulus(V, 1);
    check_output("short_strobes", 64'(strobe_q.size()), 64'd31);
    check_output("short_err", 64'(frame_err), 64'd1);
    check_output("short_done", 64'(done_cnt), 64'd1);
    check_output("short_cnt", 64'(frame_cnt), 64'd1);

    apply_stimulus(V, -1);
    check_output("recover_strobes", 64'(strobe_q.size()), 64'd32);
    check_output("recover_err", 64'(frame_err), 64'd0);
    check_output("recover_cnt", 64'(frame_cnt), 64'd2);
    check_output("recover_done", 64'(done_cnt), 64'd1);

    // One extra line: its pixels are dropped
    apply_stimulus(V + 1, -1);
    check_output("long_strobes", 64'(strobe_q.size()), 64'd32);
    check_output("long_err", 64'(frame_err), 64'd1);
    check_output("long_cnt", 64'(frame_cnt), 64'd2);
    check_output("long_done", 64'(done_cnt), 64'd1);

    // VSYNC falling edge lands on H2L_Sig_V three clocks later, one clock wide
    clear_monitor();
    @(posedge clk);
    #2 cam_vsync = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1 check_output("h2l_latency", 64'(h2l_sig_v), 64'(k == 3));
    end
    repeat (3) @(negedge cam_pclk);
    send_lines(V, -1);
    frame_end();
    check_output("latency_frame_strobes", 64'(strobe_q.size()), 64'd32);
    check_output("latency_frame_cnt", 64'(frame_cnt), 64'd3);
    check_output("latency_frame_err", 64'(frame_err), 64'd0);

    // Capture_En dropped during row 2: this frame still completes
    clear_monitor();
    frame_start();
    fork
      send_lines(V, -1);
      begin
        repeat (100) @(posedge clk);
        #1 capture_en = 1'b0;
      end
    join
    frame_end();
    check_output("endrop_strobes", 64'(strobe_q.size()), 64'd32);
    check_output("endrop_done", 64'(done_cnt), 64'd1);
    check_output("endrop_cnt", 64'(frame_cnt), 64'd4);

    apply_stimulus(V, -1);
    check_output("idle_strobes", 64'(strobe_q.size()), 64'd0);
    check_output("idle_done", 64'(done_cnt), 64'd0);
    check_output("idle_cnt", 64'(frame_cnt), 64'd4);

    // Reset held for two clocks in the middle of row 1
    capture_en = 1'b1;
    clear_monitor();
    frame_start();
    fork
      send_lines(V, -1);
      begin
        repeat (60) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 check_output("reset_mid_outputs", all_outputs(), 64'd0);
        clear_monitor();
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    frame_end();
    check_output("after_reset_strobes", 64'(strobe_q.size()), 64'd0);
    check_output("after_reset_done", 64'(done_cnt), 64'd0);

    apply_stimulus(V, -1);
    check_output("final_strobes", 64'(strobe_q.size()), 64'd32);
    check_output("final_cnt", 64'(frame_cnt), 64'd1);
    check_output("final_done", 64'(done_cnt), 64'd1);
    check_output("final_err", 64'(frame_err), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
